instr_fetch_unit: RTL and testbench

Instruction fetch sequencer that produces the instruction stream consumed by the instruction register. It owns the program counter, runs a request/acknowledge read handshake against instruction memory, and presents each fetched 16-bit word on `Instruction_Out` with a one-cycle `InstrWrite` strobe. It sits between instruction memory and the instruction register, under control of the main control FSM, which drives `Fetch_En` and the branch redirect inputs.

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: request/acknowledge handshake between the
// fetch unit (master) and instruction memory (slave).
interface instr_fetch_unit_if;
    logic        Mem_Req;
    logic [15:0] Mem_Addr;
    logic        Mem_Ack;
    logic [15:0] Mem_Data;

    modport master (
        output Mem_Req,
        output Mem_Addr,
        input  Mem_Ack,
        input  Mem_Data
    );

    modport slave (
        input  Mem_Req,
        input  Mem_Addr,
        output Mem_Ack,
        output Mem_Data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory and strobes
// each word into the instruction register. Optional REQ timeout: FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      Fetch_En,
    input  logic                      Branch_Taken,
    input  logic [15:0]               Branch_Target,
    instr_fetch_unit_if.master        mem,
    output logic [15:0]               Instruction_Out,
    output logic                      InstrWrite,
    output logic [15:0]               PC_Out,
    output logic                      Fetch_Busy,
    output logic                      Fetch_Error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic        squash_q, squash_d;
    logic        fetch_ok;
    logic [15:0] issue_addr;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT_CYCLES);

    logic       err_q, err_d;
    logic [4:0] tmo_q, tmo_d;

    // A latched fetch error blocks every new request until reset.
    assign fetch_ok = Fetch_En && !err_q;
`else
    assign fetch_ok = Fetch_En;
`endif

    // A redirect in the same cycle as the request wins over the current PC.
    assign issue_addr = Branch_Taken ? Branch_Target : pc_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= 16'h0000;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            squash_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            err_q    <= 1'b0;
            tmo_q    <= 5'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            squash_q <= squash_d;
`ifdef FETCH_TIMEOUT_EN
            err_q    <= err_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no branch can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        req_d    = req_q;
        wr_d     = 1'b0;
        squash_d = squash_q;
`ifdef FETCH_TIMEOUT_EN
        err_d    = err_q;
        tmo_d    = tmo_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (Branch_Taken) begin
                    pc_d = Branch_Target;
                end
                if (fetch_ok) begin
                    addr_d   = issue_addr;
                    req_d    = 1'b1;
                    squash_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d    = 5'd0;
`endif
                    state_d  = S_REQ;
                end
            end

            S_REQ: begin
                // A redirect while the read is in flight makes its data stale.
                if (Branch_Taken) begin
                    pc_d     = Branch_Target;
                    squash_d = 1'b1;
                end
                if (mem.Mem_Ack) begin
                    req_d    = 1'b0;
                    squash_d = 1'b0;
                    if (squash_q || Branch_Taken) begin
                        state_d = S_IDLE;
                    end else begin
                        instr_d = mem.Mem_Data;
                        wr_d    = 1'b1;
                        pc_d    = pc_q + 16'd1;
                        state_d = S_WRITE;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_q + 5'd1 == TMO_LAST) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    squash_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
`endif
            end

            S_WRITE: begin
                if (Branch_Taken) begin
                    pc_d = Branch_Target;
                end
                if (fetch_ok) begin
                    addr_d   = issue_addr;
                    req_d    = 1'b1;
                    squash_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    tmo_d    = 5'd0;
`endif
                    state_d  = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign mem.Mem_Req     = req_q;
    assign mem.Mem_Addr    = addr_q;
    assign Instruction_Out = instr_q;
    assign InstrWrite      = wr_q;
    assign PC_Out          = pc_q;
    assign Fetch_Busy      = (state_q != S_IDLE);

`ifdef FETCH_TIMEOUT_EN
    assign Fetch_Error = err_q;
`else
    assign Fetch_Error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a PC-level reference model queues the
// expected addresses and instruction writes; negedge monitors pop and compare.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Fetch_En;
    logic        Branch_Taken;
    logic [15:0] Branch_Target;
    logic [15:0] Instruction_Out;
    logic        InstrWrite;
    logic [15:0] PC_Out;
    logic        Fetch_Busy;
    logic        Fetch_Error;

    instr_fetch_unit_if mem_if ();

`ifdef FETCH_TIMEOUT_EN
    instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(4)) dut (
`else
    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
`endif
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Fetch_En        (Fetch_En),
        .Branch_Taken    (Branch_Taken),
        .Branch_Target   (Branch_Target),
        .mem             (mem_if.master),
        .Instruction_Out (Instruction_Out),
        .InstrWrite      (InstrWrite),
        .PC_Out          (PC_Out),
        .Fetch_Busy      (Fetch_Busy),
        .Fetch_Error     (Fetch_Error)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_pc;
    logic [15:0] data_xor = 16'h1111;
    logic [15:0] addr_q[$];
    wr_t         wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitors: new requests against expected addresses, writes against expected words.
    logic        prev_req  = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    always @(negedge Clk) begin
        if (Reset_n === 1'b1) begin
            if (mem_if.Mem_Req && !prev_req) begin
                if (addr_q.size() == 0)
                    flag_fail("unexpected_req", $sformatf("request at %h with no fetch issued", mem_if.Mem_Addr));
                else
                    check("mem_addr", 32'(mem_if.Mem_Addr), 32'(addr_q.pop_front()));
            end else if (mem_if.Mem_Req && prev_req) begin
                check("addr_stable", 32'(mem_if.Mem_Addr), 32'(prev_addr));
            end
            if (InstrWrite) begin
                if (wr_q.size() == 0) begin
                    flag_fail("unexpected_write", $sformatf("InstrWrite with Instruction_Out=%h", Instruction_Out));
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("instr_out", 32'(Instruction_Out), 32'(e.instr));
                    check("pc_at_write", 32'(PC_Out), 32'(e.pc));
                end
            end
        end
        prev_req  = mem_if.Mem_Req;
        prev_addr = mem_if.Mem_Addr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        Reset_n           = 1'b0;
        Fetch_En          = 1'b0;
        Branch_Taken      = 1'b0;
        Branch_Target     = 16'h0000;
        mem_if.Mem_Ack    = 1'b0;
        mem_if.Mem_Data   = 16'h0000;
        m_pc              = RESET_PC;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // One fetch from IDLE. Optional redirect at issue, during REQ (cycle br_at) and in WRITE.
    task automatic fetch_txn(input logic br_issue, input logic [15:0] t0, input int wait_cyc,
                             input logic br_req, input int br_at, input logic [15:0] t1,
                             input logic br_wr, input logic [15:0] t2);
        logic [15:0] addr;
        addr = br_issue ? t0 : m_pc;
        if (br_issue) m_pc = t0;
        addr_q.push_back(addr);
        Fetch_En      = 1'b1;
        Branch_Taken  = br_issue;
        Branch_Target = t0;
        @(negedge Clk);
        Fetch_En     = 1'b0;
        Branch_Taken = 1'b0;
        check("busy_in_req", 32'(Fetch_Busy), 32'd1);
        for (int i = 0; i <= wait_cyc; i++) begin
            Branch_Taken  = br_req && (i == br_at);
            Branch_Target = t1;
            if (i == wait_cyc) begin
                mem_if.Mem_Ack  = 1'b1;
                mem_if.Mem_Data = mem_if.Mem_Addr ^ data_xor;
                if (br_req) begin
                    m_pc = t1;
                end else begin
                    wr_t e;
                    e.instr = addr ^ data_xor;
                    e.pc    = addr + 16'd1;
                    wr_q.push_back(e);
                    m_pc = addr + 16'd1;
                end
            end else begin
                mem_if.Mem_Ack  = 1'b0;
                mem_if.Mem_Data = 16'($urandom);
            end
            @(negedge Clk);
        end
        mem_if.Mem_Ack = 1'b0;
        Branch_Taken   = 1'b0;
        if (!br_req) begin
            if (br_wr) begin
                Branch_Taken  = 1'b1;
                Branch_Target = t2;
                m_pc          = t2;
            end
            @(negedge Clk);
            Branch_Taken = 1'b0;
        end
        check("pc_after_txn", 32'(PC_Out), 32'(m_pc));
        check("busy_idle", 32'(Fetch_Busy), 32'd0);
    endtask

    task automatic idle_branch(input logic [15:0] t);
        Branch_Taken  = 1'b1;
        Branch_Target = t;
        m_pc          = t;
        @(negedge Clk);
        Branch_Taken = 1'b0;
        check("pc_idle_branch", 32'(PC_Out), 32'(m_pc));
    endtask

    // Fetch_En held high with zero-wait memory: one instruction every 2 cycles.
    task automatic back_to_back(input int n);
        addr_q.push_back(m_pc);
        Fetch_En = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < n; k++) begin
            wr_t e;
            check("b2b_no_write_in_req", 32'(InstrWrite), 32'd0);
            mem_if.Mem_Ack  = 1'b1;
            mem_if.Mem_Data = mem_if.Mem_Addr ^ data_xor;
            e.instr = m_pc ^ data_xor;
            e.pc    = m_pc + 16'd1;
            wr_q.push_back(e);
            m_pc = m_pc + 16'd1;
            if (k == n - 1) Fetch_En = 1'b0;
            else addr_q.push_back(m_pc);
            @(negedge Clk);
            mem_if.Mem_Ack = 1'b0;
            check("b2b_write_strobe", 32'(InstrWrite), 32'd1);
            if (k != n - 1) @(negedge Clk);
        end
        @(negedge Clk);
        check("b2b_pc_end", 32'(PC_Out), 32'(m_pc));
    endtask

    initial begin
        Reset_n         = 1'b0;
        Fetch_En        = 1'b0;
        Branch_Taken    = 1'b0;
        Branch_Target   = 16'h0000;
        mem_if.Mem_Ack  = 1'b0;
        mem_if.Mem_Data = 16'h0000;
        m_pc            = RESET_PC;
        #12;
        check("rst_mem_req", 32'(mem_if.Mem_Req), 32'd0);
        check("rst_mem_addr", 32'(mem_if.Mem_Addr), 32'(RESET_PC));
        check("rst_pc", 32'(PC_Out), 32'(RESET_PC));
        check("rst_instr", 32'(Instruction_Out), 32'h0000);
        check("rst_instr_write", 32'(InstrWrite), 32'd0);
        check("rst_busy", 32'(Fetch_Busy), 32'd0);
        check("rst_error", 32'(Fetch_Error), 32'd0);
        apply_reset();

        // Reset then fetch: two wait cycles, word A5C3 from address 0000.
        data_xor = 16'hA5C3;
        fetch_txn(1'b0, 16'h0, 2, 1'b0, 0, 16'h0, 1'b0, 16'h0);
        check("first_pc", 32'(PC_Out), 32'h0001);
        data_xor = 16'h1111;

        // Back-to-back from 0000: words 1111, 1110, 1113.
        apply_reset();
        back_to_back(3);

        // Branch to 0040 while the ack is pending; next fetch comes from 0040.
        fetch_txn(1'b0, 16'h0, 2, 1'b1, 1, 16'h0040, 1'b0, 16'h0);
        fetch_txn(1'b0, 16'h0, 0, 1'b0, 0, 16'h0, 1'b0, 16'h0);
        // Ack coincident with branch counts as squashed.
        fetch_txn(1'b0, 16'h0, 1, 1'b1, 1, 16'h1234, 1'b0, 16'h0);

        // PC wrap through FFFF.
        idle_branch(16'hFFFF);
        fetch_txn(1'b0, 16'h0, 0, 1'b0, 0, 16'h0, 1'b0, 16'h0);
        check("pc_wrap", 32'(PC_Out), 32'h0000);

        // Stray ack in IDLE is ignored.
        mem_if.Mem_Ack  = 1'b1;
        mem_if.Mem_Data = 16'hDEAD;
        @(negedge Clk);
        mem_if.Mem_Ack = 1'b0;
        @(negedge Clk);
        check("stray_ack_instr", 32'(Instruction_Out), 32'(16'hFFFF ^ data_xor));

        // Randomized mix of waits and redirects.
        for (int n = 0; n < 40; n++) begin
            int wc;
            wc = $urandom_range(0, 3);
            fetch_txn($urandom_range(0, 3) == 0, 16'($urandom), wc,
                      $urandom_range(0, 3) == 0, $urandom_range(0, wc), 16'($urandom),
                      $urandom_range(0, 4) == 0, 16'($urandom));
            if ($urandom_range(0, 5) == 0) idle_branch(16'($urandom));
        end

        // Reset while a request is outstanding; a late ack must be ignored.
        idle_branch(16'h0123);
        addr_q.push_back(m_pc);
        Fetch_En = 1'b1;
        @(negedge Clk);
        Fetch_En = 1'b0;
        check("pre_reset_req", 32'(mem_if.Mem_Req), 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        m_pc = RESET_PC;
        check("async_rst_req", 32'(mem_if.Mem_Req), 32'd0);
        check("async_rst_pc", 32'(PC_Out), 32'(RESET_PC));
        check("async_rst_busy", 32'(Fetch_Busy), 32'd0);
        @(negedge Clk);
        Reset_n         = 1'b1;
        mem_if.Mem_Ack  = 1'b1;
        mem_if.Mem_Data = 16'hBEEF;
        repeat (2) @(negedge Clk);
        mem_if.Mem_Ack = 1'b0;
        @(negedge Clk);
        check("late_ack_instr", 32'(Instruction_Out), 32'h0000);
        check("late_ack_pc", 32'(PC_Out), 32'(RESET_PC));

`ifdef FETCH_TIMEOUT_EN
        // No ack: request drops after 4 REQ cycles and the error sticks.
        begin
            int req_cycles;
            idle_branch(16'h0200);
            addr_q.push_back(m_pc);
            Fetch_En = 1'b1;
            @(negedge Clk);
            Fetch_En   = 1'b0;
            req_cycles = 0;
            while (mem_if.Mem_Req && req_cycles < 20) begin
                req_cycles++;
                @(negedge Clk);
            end
            check("timeout_req_cycles", 32'(req_cycles), 32'd4);
            check("timeout_error", 32'(Fetch_Error), 32'd1);
            check("timeout_pc", 32'(PC_Out), 32'(m_pc));
            Fetch_En = 1'b1;
            repeat (3) begin
                @(negedge Clk);
                check("fetch_blocked", 32'(mem_if.Mem_Req), 32'd0);
            end
            Fetch_En = 1'b0;
            check("blocked_pc", 32'(PC_Out), 32'(m_pc));
            apply_reset();
            check("error_cleared", 32'(Fetch_Error), 32'd0);
        end
`else
        check("no_timeout_error", 32'(Fetch_Error), 32'd0);
`endif

        check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        check("write_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
